// File: rtl/fetch_stage_pkg.sv
// Shared constants for the RV32I fetch stage.
package fetch_stage_pkg;

    localparam logic [6:0]  OPC_OP_IMM = 7'b001_0011;
    // addi x0, x0, 0
    localparam logic [31:0] NOP        = {12'h000, 5'd0, 3'b000, 5'd0, OPC_OP_IMM};

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO used for the prefetch buffer and the request-PC queue.
// Flush has priority over push and pop; push into a full FIFO is dropped and flagged.
module fetch_fifo #(
    parameter  int unsigned DEPTH = 2,
    parameter  int unsigned WIDTH = 64,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush && !i_rst) r_mem[r_wptr] <= i_wdata;
    end

    assert property (@(posedge i_clk) disable iff (i_rst || i_flush) i_push |-> !o_full);

endmodule

// File: rtl/fetch_stage.sv
// IF stage and IF/ID register: PC generation, in-order imem requests, prefetch FIFO.
// Optional FETCH_PERF_CNT_EN adds saturating stall/bubble cycle counters.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
`ifdef FETCH_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W      = 32
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:1]       stall,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic             imem_req_valid,
    output logic [31:0]      imem_req_addr,
    input  logic             imem_req_ready,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_data,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc,
    output logic             if_id_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_stall_cyc,
    output logic [CNT_W-1:0] perf_bubble_cyc
`endif
);

    localparam int unsigned    CW      = $clog2(FIFO_DEPTH) + 1;
    // Discard can accumulate across back-to-back redirects, so give it headroom.
    localparam int unsigned    DW      = CW + 2;
    localparam logic [CW:0]    DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    logic [31:0]   r_pc;
    logic [CW-1:0] r_outstanding;
    logic [DW-1:0] r_discard;
    logic [31:0]   r_if_id_instr;
    logic [31:0]   r_if_id_pc;
    logic          r_if_id_valid;

    logic [31:0]   w_pc_nxt;
    logic [CW-1:0] w_out_nxt;
    logic [DW-1:0] w_disc_nxt;
    logic [DW-1:0] w_inflight;
    logic [31:0]   w_instr_nxt;
    logic [31:0]   w_ifpc_nxt;
    logic          w_valid_nxt;
    logic [CW:0]   w_credit;
    logic          w_accept;
    logic          w_keep;
    logic          w_pop;
    logic          w_bubble;
    logic [63:0]   w_fifo_rdata;
    logic [CW-1:0] w_fifo_count;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [31:0]   w_pcq_head;
    logic [CW-1:0] w_pcq_count;
    logic          w_pcq_full;
    logic          w_pcq_empty;
    logic          w_unused;

    assign w_credit       = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
    assign imem_req_valid = ~rst & ~stall[1] & ~redirect_valid & (w_credit < DEPTH_C);
    assign imem_req_addr  = r_pc;
    assign w_accept       = imem_req_valid & imem_req_ready;
    // Only responses to live requests enter the FIFO; stale or spurious ones are dropped.
    assign w_keep         = imem_rsp_valid & ~redirect_valid & (r_discard == '0)
                          & (r_outstanding != '0);
    assign w_pop          = ~redirect_valid & ~stall[2] & ~w_fifo_empty;
    assign w_bubble       = redirect_valid | (~stall[2] & w_fifo_empty);
    assign w_inflight     = r_discard + DW'(r_outstanding);
    assign w_unused       = ^{redirect_pc[1:0], stall[5:3], w_fifo_full, w_pcq_count,
                              w_pcq_full, w_pcq_empty};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (w_keep),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_wdata ({imem_rsp_data, w_pcq_head}),
        .o_rdata (w_fifo_rdata),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_pc_queue (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (w_accept),
        .i_pop   (w_keep),
        .i_flush (redirect_valid),
        .i_wdata (r_pc),
        .o_rdata (w_pcq_head),
        .o_count (w_pcq_count),
        .o_full  (w_pcq_full),
        .o_empty (w_pcq_empty)
    );

    always_comb begin
        w_pc_nxt    = r_pc;
        w_out_nxt   = r_outstanding;
        w_disc_nxt  = r_discard;
        w_instr_nxt = NOP;
        w_ifpc_nxt  = r_if_id_pc;
        w_valid_nxt = 1'b0;
        if (redirect_valid) begin
            w_pc_nxt   = {redirect_pc[31:2], 2'b00};
            w_out_nxt  = '0;
            w_disc_nxt = (imem_rsp_valid && w_inflight != '0) ? w_inflight - DW'(1)
                                                              : w_inflight;
        end else begin
            if (w_accept) w_pc_nxt = r_pc + 32'd4;
            if (w_accept && !w_keep)      w_out_nxt = r_outstanding + CW'(1);
            else if (!w_accept && w_keep) w_out_nxt = r_outstanding - CW'(1);
            if (imem_rsp_valid && r_discard != '0) w_disc_nxt = r_discard - DW'(1);
            if (stall[2]) begin
                w_instr_nxt = r_if_id_instr;
                w_valid_nxt = r_if_id_valid;
            end else if (!w_fifo_empty) begin
                w_instr_nxt = w_fifo_rdata[63:32];
                w_ifpc_nxt  = w_fifo_rdata[31:0];
                w_valid_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_if_id_instr <= NOP;
            r_if_id_pc    <= '0;
            r_if_id_valid <= 1'b0;
        end else begin
            r_pc          <= w_pc_nxt;
            r_outstanding <= w_out_nxt;
            r_discard     <= w_disc_nxt;
            r_if_id_instr <= w_instr_nxt;
            r_if_id_pc    <= w_ifpc_nxt;
            r_if_id_valid <= w_valid_nxt;
        end
    end

    assign if_id_instr = r_if_id_instr;
    assign if_id_pc    = r_if_id_pc;
    assign if_id_valid = r_if_id_valid;

    assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (r_discard != '0 || r_outstanding != '0));

`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] r_perf_stall;
    logic [CNT_W-1:0] r_perf_bubble;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_stall  <= '0;
            r_perf_bubble <= '0;
        end else begin
            if (stall[2] && r_perf_stall != {CNT_W{1'b1}})
                r_perf_stall <= r_perf_stall + CNT_W'(1);
            if (w_bubble && r_perf_bubble != {CNT_W{1'b1}})
                r_perf_bubble <= r_perf_bubble + CNT_W'(1);
        end
    end

    assign perf_stall_cyc  = r_perf_stall;
    assign perf_bubble_cyc = r_perf_bubble;
`else
    logic w_unused_bubble;
    assign w_unused_bubble = w_bubble;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an in-order, fixed-latency instruction memory model.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk;
    logic        rst;
    logic [5:1]  stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cyc;
    logic [31:0] perf_bubble_cyc;
`endif

    int          n_checks;
    int          n_fails;
    int          cyc;
    int          lat;
    logic [31:0] addr_q[$];
    int          due_q[$];

    fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .if_id_instr     (if_id_instr),
        .if_id_pc        (if_id_pc),
        .if_id_valid     (if_id_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall_cyc  (perf_stall_cyc),
        .perf_bubble_cyc (perf_bubble_cyc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: record accepts before the edge, present due responses just after it.
    task automatic tick();
        @(negedge clk);
        if (imem_req_valid && imem_req_ready) begin
            addr_q.push_back(imem_req_addr);
            due_q.push_back(cyc + lat);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (addr_q.size() > 0 && due_q[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(addr_q[0]);
            void'(addr_q.pop_front());
            void'(due_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst            = 1'b1;
        imem_rsp_valid = 1'b0;
        addr_q.delete();
        due_q.delete();
        tick();
        chk({tag, "_instr"}, if_id_instr, NOP);
        chk({tag, "_pc"}, if_id_pc, 32'h0);
        chk({tag, "_valid"}, 32'(if_id_valid), 32'd0);
        chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        tick();
        rst = 1'b0;
        cyc = 0;
        #1;
    endtask

    initial begin
        n_checks       = 0;
        n_fails        = 0;
        cyc            = 0;
        lat            = 1;
        rst            = 1'b1;
        stall          = 5'b00000;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        #2;

        // Streaming with 1-cycle memory
        do_reset("rst0");
        chk("c0_req_valid", 32'(imem_req_valid), 32'd1);
        chk("c0_addr", imem_req_addr, 32'h0);
        tick();
        chk("c1_addr", imem_req_addr, 32'h4);
        chk("c1_req_valid", 32'(imem_req_valid), 32'd1);
        chk("c1_if_valid", 32'(if_id_valid), 32'd0);
        tick();
        chk("c2_req_credit", 32'(imem_req_valid), 32'd0);
        chk("c2_if_valid", 32'(if_id_valid), 32'd0);
        tick();
        chk("c3_if_valid", 32'(if_id_valid), 32'd1);
        chk("c3_if_pc", if_id_pc, 32'h0);
        chk("c3_if_instr", if_id_instr, instr_of(32'h0));
        tick();
        chk("c4_if_pc", if_id_pc, 32'h4);
        tick();
        chk("c5_bubble_valid", 32'(if_id_valid), 32'd0);
        chk("c5_bubble_instr", if_id_instr, NOP);
        tick();
        chk("c6_if_pc", if_id_pc, 32'h8);

        // One-cycle stall of PC and IF/ID
        stall = 5'b00111;
        #1;
        chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        stall = 5'b00000;
        #1;
        chk("stall_hold_pc", if_id_pc, 32'h8);
        chk("stall_hold_valid", 32'(if_id_valid), 32'd1);
        chk("stall_hold_addr", imem_req_addr, 32'h10);
        chk("stall_release_req", 32'(imem_req_valid), 32'd1);
        tick();
        chk("after_stall_pc", if_id_pc, 32'hC);
        chk("after_stall_instr", if_id_instr, instr_of(32'hC));
        tick();
        tick();
        chk("after_stall_next", if_id_pc, 32'h10);

        // Redirect with two requests in flight, 3-cycle memory; also mid-operation reset
        lat = 3;
        do_reset("rst1");
        tick();
        chk("r_c1_addr", imem_req_addr, 32'h4);
        tick();
        chk("r_c2_credit", 32'(imem_req_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        #1;
        chk("r_req_blocked", 32'(imem_req_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("r_c3_if_valid", 32'(if_id_valid), 32'd0);
        chk("r_c3_addr", imem_req_addr, 32'h100);
        chk("r_c3_req_valid", 32'(imem_req_valid), 32'd1);
        repeat (4) tick();
        chk("r_c7_if_valid", 32'(if_id_valid), 32'd0);
        chk("r_c7_if_instr", if_id_instr, NOP);
        tick();
        chk("r_c8_if_pc", if_id_pc, 32'h100);
        chk("r_c8_if_instr", if_id_instr, instr_of(32'h100));
        chk("r_c8_if_valid", 32'(if_id_valid), 32'd1);
        tick();
        chk("r_c9_if_pc", if_id_pc, 32'h104);

        // Redirect and IF/ID stall in the same cycle
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        stall          = 5'b00110;
        #1;
        chk("rs_req_blocked", 32'(imem_req_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        stall          = 5'b00000;
        #1;
        chk("rs_if_valid", 32'(if_id_valid), 32'd0);
        chk("rs_if_instr", if_id_instr, NOP);
        chk("rs_addr", imem_req_addr, 32'h200);
        repeat (4) tick();
        chk("rs_c14_if_valid", 32'(if_id_valid), 32'd0);
        tick();
        chk("rs_c15_if_pc", if_id_pc, 32'h200);
        chk("rs_c15_if_instr", if_id_instr, instr_of(32'h200));
        tick();
        chk("rs_c16_if_pc", if_id_pc, 32'h204);

        // Memory not ready for five cycles
        lat = 1;
        do_reset("rst2");
        repeat (6) tick();
        chk("nr_c6_if_pc", if_id_pc, 32'h8);
        imem_req_ready = 1'b0;
        tick();
        chk("nr_c7_if_pc", if_id_pc, 32'hC);
        tick();
        chk("nr_c8_if_valid", 32'(if_id_valid), 32'd0);
        chk("nr_c8_if_instr", if_id_instr, NOP);
        chk("nr_c8_addr", imem_req_addr, 32'h10);
        chk("nr_c8_req_valid", 32'(imem_req_valid), 32'd1);
        tick();
        tick();
        chk("nr_c10_if_valid", 32'(if_id_valid), 32'd0);
        chk("nr_c10_addr", imem_req_addr, 32'h10);
        tick();
        imem_req_ready = 1'b1;
        chk("nr_c11_addr", imem_req_addr, 32'h10);
        repeat (3) tick();
        chk("nr_c14_if_pc", if_id_pc, 32'h10);
        chk("nr_c14_if_valid", 32'(if_id_valid), 32'd1);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("wrap_addr_top", imem_req_addr, 32'hFFFF_FFFC);
        chk("wrap_req_valid", 32'(imem_req_valid), 32'd1);
        tick();
        chk("wrap_addr_zero", imem_req_addr, 32'h0);
        tick();
        tick();
        chk("wrap_if_pc_top", if_id_pc, 32'hFFFF_FFFC);
        chk("wrap_if_instr_top", if_id_instr, instr_of(32'hFFFF_FFFC));
        tick();
        chk("wrap_if_pc_zero", if_id_pc, 32'h0);
        chk("wrap_if_instr_zero", if_id_instr, instr_of(32'h0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
